// File: rtl/snd_pkg.sv
// Shared types and constants for the snake-game sound-effect sequencer:
// FSM state, pending-event slot, note ROM entry layout and effect start indices.
package snd_pkg;

  localparam int IDX_W     = 3;
  localparam int HALF_W    = 8;
  localparam int LEN_W     = 8;
  localparam int PHASE_W   = 8;
  localparam int ROM_DEPTH = 6;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } state_t;

  // Single pending slot; DIE outranks EAT when both are waiting for a tick.
  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_EAT,
    PEND_DIE
  } pend_t;

  localparam logic [IDX_W-1:0] EAT_START = 3'd0;
  localparam logic [IDX_W-1:0] DIE_START = 3'd2;

  typedef struct packed {
    logic [HALF_W-1:0] half_period;  // samples per half square-wave period
    logic [LEN_W-1:0]  length;       // note length in NOTE_UNIT sample ticks
    logic              last;         // final note of the effect
  } note_t;

  function automatic note_t mk_note(input logic [HALF_W-1:0] half_period,
                                    input logic [LEN_W-1:0]  length,
                                    input logic              last);
    note_t n;
    n.half_period = half_period;
    n.length      = length;
    n.last        = last;
    return n;
  endfunction

endpackage

// File: rtl/snd_fx_seq_if.sv
// Event/mute inputs and PWM-facing outputs of the sound-effect sequencer.
// The game logic side is the master; the sequencer is the slave.
interface snd_fx_seq_if #(
  parameter int R_SIZE = 8
);

  logic              eat_evt;
  logic              die_evt;
  logic              mute;
  logic [R_SIZE:0]   duty;
  logic              load;
  logic              sample_stb;
  logic              busy;

  modport master (
    output eat_evt, die_evt, mute,
    input  duty, load, sample_stb, busy
  );

  modport slave (
    input  eat_evt, die_evt, mute,
    output duty, load, sample_stb, busy
  );

endinterface

// File: rtl/snd_fx_rom.sv
// Combinational 6-entry note ROM: EAT occupies entries 0-1, DIE entries 2-5.
module snd_fx_rom
  import snd_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output note_t            note
);

  always_comb begin
    case (idx)
      3'd0:    note = mk_note(8'd50,  8'd4,  1'b0);
      3'd1:    note = mk_note(8'd35,  8'd6,  1'b1);
      3'd2:    note = mk_note(8'd60,  8'd8,  1'b0);
      3'd3:    note = mk_note(8'd80,  8'd8,  1'b0);
      3'd4:    note = mk_note(8'd100, 8'd8,  1'b0);
      3'd5:    note = mk_note(8'd140, 8'd16, 1'b1);
      // Unreachable indices end the effect at once rather than run on.
      default: note = mk_note(8'd1,   8'd1,  1'b1);
    endcase
  end

endmodule

// File: rtl/snd_fx_seq.sv
// Sound-effect sequencer: turns eat/die pulses into square-wave note sequences
// presented as a per-sample PWM duty value with a permanent load strobe.
module snd_fx_seq
  import snd_pkg::*;
#(
  parameter int R_SIZE     = 8,
  parameter int SAMPLE_DIV = 256,
  parameter int NOTE_UNIT  = 1024,
  parameter int GAP_UNITS  = 1
) (
  input  logic         clk,
  input  logic         rst,
  snd_fx_seq_if.slave  bus
);

  localparam int DIV_W     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int NOTE_MAX  = 255 * NOTE_UNIT;
  localparam int GAP_TICKS = GAP_UNITS * NOTE_UNIT;
  localparam int DUR_W     = $clog2(((NOTE_MAX > GAP_TICKS) ? NOTE_MAX : GAP_TICKS) + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DUR_W-1:0]  GAP_LAST = DUR_W'(GAP_TICKS - 1);
  localparam logic [DUR_W-1:0]  NOTE_MUL = DUR_W'(NOTE_UNIT);
  localparam logic [R_SIZE:0]   DUTY_ON  = {2'b01, {(R_SIZE-1){1'b0}}};

  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic               stb_q;
  logic               load_q;
  logic [R_SIZE:0]    duty_q;
  logic [R_SIZE:0]    duty_nxt;

  pend_t              pend, pend_nxt;
  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               level, level_nxt;
  logic [PHASE_W-1:0] phase, phase_nxt;
  logic [DUR_W-1:0]   dur, dur_nxt;
  logic               is_die, is_die_nxt;

  note_t              note;
  logic [PHASE_W-1:0] phase_end;
  logic [DUR_W-1:0]   note_end;
  logic               die_active;
  logic               start_die;
  logic               start_eat;

  snd_fx_rom u_rom (
    .idx  (idx),
    .note (note)
  );

  assign tick       = (div_cnt == DIV_LAST);
  assign phase_end  = note.half_period - 8'd1;
  assign note_end   = DUR_W'(note.length) * NOTE_MUL - DUR_W'(1);
  assign die_active = (state != IDLE) && is_die;
  // EAT only restarts when the effect running up to this tick is not DIE.
  assign start_die  = tick && (pend == PEND_DIE);
  assign start_eat  = tick && (pend == PEND_EAT) && !die_active;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      stb_q   <= 1'b0;
      load_q  <= 1'b0;
      duty_q  <= '0;
      pend    <= PEND_NONE;
      state   <= IDLE;
      idx     <= '0;
      level   <= 1'b0;
      phase   <= '0;
      dur     <= '0;
      is_die  <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      stb_q   <= tick;
      load_q  <= 1'b1;
      if (tick) duty_q <= duty_nxt;
      pend    <= pend_nxt;
      state   <= state_nxt;
      idx     <= idx_nxt;
      level   <= level_nxt;
      phase   <= phase_nxt;
      dur     <= dur_nxt;
      is_die  <= is_die_nxt;
    end
  end

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pend_nxt   = tick ? PEND_NONE : pend;
    state_nxt  = state;
    idx_nxt    = idx;
    level_nxt  = level;
    phase_nxt  = phase;
    dur_nxt    = dur;
    is_die_nxt = is_die;

    // A pulse in the tick cycle lands in the freshly cleared slot.
    if (bus.die_evt) begin
      pend_nxt = PEND_DIE;
    end else if (bus.eat_evt && (pend_nxt != PEND_DIE) && !die_active) begin
      pend_nxt = PEND_EAT;
    end

    if (start_die || start_eat) begin
      state_nxt  = PLAY;
      idx_nxt    = start_die ? DIE_START : EAT_START;
      level_nxt  = 1'b1;
      phase_nxt  = '0;
      dur_nxt    = '0;
      is_die_nxt = start_die;
    end else if (tick) begin
      case (state)
        PLAY: begin
          if (phase == phase_end) begin
            phase_nxt = '0;
            level_nxt = ~level;
          end else begin
            phase_nxt = phase + 8'd1;
          end
          if (dur == note_end) begin
            dur_nxt   = '0;
            state_nxt = note.last ? IDLE : GAP;
          end else begin
            dur_nxt = dur + DUR_W'(1);
          end
        end
        GAP: begin
          if (dur == GAP_LAST) begin
            dur_nxt   = '0;
            phase_nxt = '0;
            level_nxt = 1'b1;
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = PLAY;
          end else begin
            dur_nxt = dur + DUR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Duty reflects the post-tick state; mute only gates the output value.
  always_comb begin
    duty_nxt = '0;
    if ((state_nxt == PLAY) && level_nxt && !bus.mute) duty_nxt = DUTY_ON;
  end

  assign bus.duty       = duty_q;
  assign bus.load       = load_q;
  assign bus.sample_stb = stb_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_snd_fx_seq.sv
// Self-checking bench for snd_fx_seq: directed effect scenarios plus random
// event/mute traffic, compared each cycle against a sample-queue reference model.
module tb_snd_fx_seq;

  localparam int R_SIZE     = 8;
  localparam int SAMPLE_DIV = 4;
  localparam int NOTE_UNIT  = 2;
  localparam int GAP_UNITS  = 1;
  localparam int DUTY_ON    = 1 << (R_SIZE - 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  snd_fx_seq_if #(.R_SIZE(R_SIZE)) bus ();

  snd_fx_seq #(
    .R_SIZE     (R_SIZE),
    .SAMPLE_DIV (SAMPLE_DIV),
    .NOTE_UNIT  (NOTE_UNIT),
    .GAP_UNITS  (GAP_UNITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference note table: EAT = entries 0-1, DIE = entries 2-5.
  int rom_half [6] = '{50, 35, 60, 80, 100, 140};
  int rom_len  [6] = '{4, 6, 8, 8, 8, 16};
  int rom_last [6] = '{0, 1, 0, 0, 0, 1};

  // Model: an effect is expanded into one tone bit per sample tick.
  bit q[$];
  int cnt;
  int pend;          // 0 none, 1 eat, 2 die
  bit cur_die;
  bit exp_busy;
  bit exp_stb;
  bit exp_load;
  int exp_duty;

  int busy_ticks;
  int tone_ticks;

  task automatic model_reset();
    q.delete();
    cnt      = 0;
    pend     = 0;
    cur_die  = 1'b0;
    exp_busy = 1'b0;
    exp_stb  = 1'b0;
    exp_load = 1'b0;
    exp_duty = 0;
  endtask

  task automatic build(input int start);
    int i = start;
    bit done = 1'b0;
    q.delete();
    while (!done) begin
      for (int k = 0; k < rom_len[i] * NOTE_UNIT; k++)
        q.push_back(((k / rom_half[i]) % 2) == 0);
      if (rom_last[i] != 0) begin
        done = 1'b1;
      end else begin
        for (int g = 0; g < GAP_UNITS * NOTE_UNIT; g++) q.push_back(1'b0);
        i++;
      end
    end
  endtask

  task automatic model_update();
    bit tick = (cnt == SAMPLE_DIV - 1);
    bit die_running = exp_busy && cur_die;
    int old_pend = pend;
    int base = tick ? 0 : pend;
    bit tone;
    if (bus.die_evt) pend = 2;
    else if (bus.eat_evt && base != 2 && !die_running) pend = 1;
    else pend = base;
    if (tick) begin
      if (old_pend == 2) begin
        build(2);
        cur_die = 1'b1;
      end else if (old_pend == 1 && !die_running) begin
        build(0);
        cur_die = 1'b0;
      end
      if (q.size() > 0) begin
        tone     = q.pop_front();
        exp_busy = 1'b1;
        exp_duty = (tone && !bus.mute) ? DUTY_ON : 0;
      end else begin
        exp_busy = 1'b0;
        exp_duty = 0;
      end
    end
    exp_stb  = tick;
    exp_load = 1'b1;
    cnt      = (cnt + 1) % SAMPLE_DIV;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_update();
    @(negedge clk);
    check("duty", int'(bus.duty), exp_duty);
    check("busy", int'(bus.busy), int'(exp_busy));
    check("sample_stb", int'(bus.sample_stb), int'(exp_stb));
    check("load", int'(bus.load), int'(exp_load));
    if (bus.sample_stb && bus.busy) busy_ticks++;
    if (bus.sample_stb && bus.duty != '0) tone_ticks++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse(input bit eat, input bit die);
    bus.eat_evt = eat;
    bus.die_evt = die;
    cycle();
    bus.eat_evt = 1'b0;
    bus.die_evt = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_duty"}, int'(bus.duty), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_stb"},  int'(bus.sample_stb), 0);
    check({tag, "_load"}, int'(bus.load), 0);
  endtask

  initial begin
    bus.eat_evt = 1'b0;
    bus.die_evt = 1'b0;
    bus.mute    = 1'b0;
    model_reset();

    #1 rst = 1'b1;
    #3 check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    run(12);

    // Single EAT: 8 + 2 + 12 busy ticks.
    busy_ticks = 0;
    pulse(1'b1, 1'b0);
    run(100);
    check("eat_busy_ticks", busy_ticks, 22);

    // Single DIE: 16+2+16+2+16+2+32 busy ticks.
    busy_ticks = 0;
    pulse(1'b0, 1'b1);
    run(360);
    check("die_busy_ticks", busy_ticks, 86);

    // Simultaneous events: DIE wins.
    busy_ticks = 0;
    pulse(1'b1, 1'b1);
    run(360);
    check("both_busy_ticks", busy_ticks, 86);

    // EAT during DIE is dropped.
    busy_ticks = 0;
    pulse(1'b0, 1'b1);
    run(50);
    pulse(1'b1, 1'b0);
    run(310);
    check("eat_in_die_ticks", busy_ticks, 86);

    // DIE during EAT restarts as DIE.
    pulse(1'b1, 1'b0);
    run(30);
    pulse(1'b0, 1'b1);
    run(380);

    // Muted EAT: same timing, no tone.
    busy_ticks = 0;
    tone_ticks = 0;
    bus.mute   = 1'b1;
    pulse(1'b1, 1'b0);
    run(100);
    bus.mute = 1'b0;
    check("mute_busy_ticks", busy_ticks, 22);
    check("mute_tone_ticks", tone_ticks, 0);

    // Mute released mid-note.
    bus.mute = 1'b1;
    pulse(1'b1, 1'b0);
    run(20);
    bus.mute = 1'b0;
    run(80);

    // Asynchronous reset in the middle of DIE, then a fresh EAT.
    pulse(1'b0, 1'b1);
    run(40);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    busy_ticks = 0;
    pulse(1'b1, 1'b0);
    run(100);
    check("post_rst_eat_ticks", busy_ticks, 22);

    // Random event and mute traffic.
    for (int i = 0; i < 4000; i++) begin
      bus.eat_evt = ($urandom_range(0, 39) == 0);
      bus.die_evt = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) bus.mute = ~bus.mute;
      cycle();
    end
    bus.eat_evt = 1'b0;
    bus.die_evt = 1'b0;
    bus.mute    = 1'b0;
    run(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
